// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Optional overflow output is enabled with SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef struct packed {
        logic sum;
        logic carry;
    } fa_res_t;

    function automatic fa_res_t fa_eval(input logic a, input logic b, input logic c);
        fa_res_t r;
        r.sum   = a ^ b ^ c;
        r.carry = (a & b) | (a & c) | (b & c);
        return r;
    endfunction

endpackage

// File: rtl/serial_bit_adder_full_adder_bit.sv
// Single-bit combinational full adder cell.
// Used once by serial_bit_adder (SERIAL_ADDER_OVF_EN has no effect here).
import serial_adder_pkg::*;

module full_adder_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic carry_o
);

    fa_res_t res;

    assign res     = fa_eval(a_i, b_i, c_i);
    assign sum_o   = res.sum;
    assign carry_o = res.carry;

endmodule

// File: rtl/serial_bit_adder.sv
// Bit-serial LSB-first adder with word framing and parallel sum capture.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
import serial_adder_pkg::*;

module serial_bit_adder #(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    output logic             s,
    output logic             cout,
    output logic             word_done,
    output logic [WIDTH-1:0] sum_word
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             carry_q;
    logic [WIDTH-2:0] sh_q, sh_d;
    logic [WIDTH-1:0] assembled;
    logic             s_q, cout_q, done_q;
    logic [WIDTH-1:0] sum_word_q, sum_word_d;
    logic             c_eff, fa_sum, fa_carry, last_bit;

    assign last_bit = (bit_cnt_q == LAST);
    // The previous word's carry never leaks into bit 0.
    assign c_eff    = (bit_cnt_q == '0) ? cin : carry_q;

    full_adder_bit u_fa (
        .a_i     (a),
        .b_i     (b),
        .c_i     (c_eff),
        .sum_o   (fa_sum),
        .carry_o (fa_carry)
    );

    assign assembled = {fa_sum, sh_q};

    always_comb begin
        bit_cnt_d  = last_bit ? '0 : bit_cnt_q + 1'b1;
        sh_d       = assembled[WIDTH-1:1];
        sum_word_d = last_bit ? assembled : sum_word_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_q  <= '0;
            carry_q    <= 1'b0;
            sh_q       <= '0;
            s_q        <= 1'b0;
            cout_q     <= 1'b0;
            done_q     <= 1'b0;
            sum_word_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            carry_q    <= fa_carry;
            sh_q       <= sh_d;
            s_q        <= fa_sum;
            cout_q     <= fa_carry;
            done_q     <= last_bit;
            sum_word_q <= sum_word_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // Signed overflow: carry into the MSB differs from carry out of it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (last_bit) begin
            ovf_q <= c_eff ^ fa_carry;
        end
    end

    assign ovf = ovf_q;
`endif

    assign s         = s_q;
    assign cout      = cout_q;
    assign word_done = done_q;
    assign sum_word  = sum_word_q;

endmodule

// File: tb/tb_serial_bit_adder.sv
// Self-checking bench for serial_bit_adder against a word-level arithmetic model.
// Build with SERIAL_ADDER_OVF_EN defined to also check ovf.
module tb_serial_bit_adder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         a, b, cin;
    logic         s, cout, word_done;
    logic [W-1:0] sum_word;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         exp_ovf;
`endif

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_sum_word;

    serial_bit_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
        .word_done (word_done),
        .sum_word  (sum_word)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one word LSB first; noise randomizes cin on bits 1..W-1.
    task automatic run_word(input int av, input int bv, input int ci, input bit noise,
                            input bit fixed_noise);
        int total, part, mask;
        int sa, sb, sx;
        total = av + bv + ci;
        for (int i = 0; i < W; i++) begin
            a   = av[i];
            b   = bv[i];
            if (i == 0)
                cin = ci[0];
            else if (fixed_noise)
                cin = 1'b1;
            else
                cin = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge clk);
            #1;
            mask = (1 << (i + 1)) - 1;
            part = (av & mask) + (bv & mask) + ci;
            check($sformatf("s[%0d]", i), 32'(s), 32'((total >> i) & 1));
            check($sformatf("cout[%0d]", i), 32'(cout), 32'((part >> (i + 1)) & 1));
            check($sformatf("word_done[%0d]", i), 32'(word_done), 32'(i == W - 1));
            if (i == W - 1) begin
                exp_sum_word = W'(total);
`ifdef SERIAL_ADDER_OVF_EN
                sa = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
                sb = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
                sx = sa + sb + ci;
                exp_ovf = (sx > (1 << (W - 1)) - 1) || (sx < -(1 << (W - 1)));
`else
                sa = 0; sb = 0; sx = 0;
`endif
            end
            check($sformatf("sum_word[%0d]", i), 32'(sum_word), 32'(exp_sum_word));
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("ovf[%0d]", i), 32'(ovf), 32'(exp_ovf));
`endif
        end
    endtask

    initial begin
        reset = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0;
        exp_sum_word = '0;
`ifdef SERIAL_ADDER_OVF_EN
        exp_ovf = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_s", 32'(s), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
        check("rst_done", 32'(word_done), 32'(0));
        check("rst_sum_word", 32'(sum_word), 32'(0));
        reset = 1'b1;

        // 15 + 13 + 1 = 29
        run_word(15, 13, 1, 1'b0, 1'b0);
        run_word(15, 13, 1, 1'b0, 1'b1);
        run_word(0, 0, 0, 1'b0, 1'b0);
        run_word(1, 0, 0, 1'b0, 1'b0);
        run_word(15, 15, 1, 1'b0, 1'b0);
        run_word(0, 0, 0, 1'b0, 1'b0);
        run_word(7, 1, 0, 1'b0, 1'b0);
        run_word(8, 8, 0, 1'b0, 1'b0);

        // Abort a word after two bits.
        a = 1'b1; b = 1'b1; cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_s", 32'(s), 32'(0));
        check("mid_rst_cout", 32'(cout), 32'(0));
        check("mid_rst_done", 32'(word_done), 32'(0));
        check("mid_rst_sum_word", 32'(sum_word), 32'(0));
        exp_sum_word = '0;
`ifdef SERIAL_ADDER_OVF_EN
        check("mid_rst_ovf", 32'(ovf), 32'(0));
        exp_ovf = 1'b0;
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_word(6, 3, 1, 1'b0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            run_word(int'($urandom_range(0, (1 << W) - 1)),
                     int'($urandom_range(0, (1 << W) - 1)),
                     int'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_bit_adder.md
Name: serial_bit_adder

Overview:
- Bit-serial ripple adder: consumes one bit of operands A and B per clock, LSB first, and produces one sum bit per clock.
- A single carry flip-flop chains the bits together.
- A word counter frames WIDTH-bit words; cin is the carry-in of each word.
- Also emits the assembled parallel sum and a word-done strobe for downstream datapath logic.

Parameters:
- WIDTH, 4, bits per serial word (≥2); sets the bit-counter range and the sum_word width.
- CNT_W, $clog2(WIDTH), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- a  input  1  current operand-A bit (LSB first).
- b  input  1  current operand-B bit (LSB first).
- cin  input  1  word carry-in; sampled only on the first bit of a word (bit_cnt==0), ignored otherwise.
- s  output  1  registered sum bit of the bit just added.
- cout  output  1  registered carry out of the bit just added.
- word_done  output  1  one-cycle pulse: the s/cout just registered were the MSB of a word.
- sum_word  output  WIDTH  parallel sum of the last completed word; held until the next word completes.

Behaviour:
- Reset (reset==0, asynchronous):
  - s=0, cout=0, word_done=0, sum_word=0.
  - Internal carry_q=0, bit_cnt=0, shift register sh=0.
- Each rising clk edge with reset==1:
  - c_eff = (bit_cnt==0) ? cin : carry_q.
  - s <= a^b^c_eff.
  - cout <= carry_q <= (a&b)|(a&c_eff)|(b&c_eff).
  - sh <= {a^b^c_eff, sh[WIDTH-1:1]} (LSB-first assembly).
  - bit_cnt <= (bit_cnt==WIDTH-1) ? 0 : bit_cnt+1.
  - word_done <= (bit_cnt==WIDTH-1).
  - When bit_cnt==WIDTH-1: sum_word <= {new sum bit, sh[WIDTH-1:1]}.
- Latency: one clock from input bit to s/cout.
- Throughput: one bit per clock, no stalls, no handshake; words are back-to-back.
- Word boundary: the carry out of the MSB appears on cout in the word_done cycle.
  - The next word's bit 0 uses cin, not carry_q. The previous word's carry is never propagated.
- Reset mid-word: the word is aborted, bit_cnt=0, and the next sampled bit is treated as bit 0 with cin.
- Reset release: first active edge is bit 0.
- All outputs are driven from flops only; no combinational input-to-output path.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output ovf (1 bit) = signed overflow of the completed word, i.e. carry into MSB XOR carry out of MSB.
  - Registered together with word_done and held until the next word_done. Reset value 0.
- When undefined:
  - The port and its logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg: DEFAULT_WIDTH=4 and a full-adder result struct typedef {logic sum; logic carry;}.
- One natural sub-module: full_adder_bit, a combinational a/b/c -> sum/carry cell instantiated once.
- Counter, carry flop and shift/capture registers stay in the top.

Test Plan:
- Reset: hold reset=0 for 2 cycles with a=b=cin=0 -> s=0, cout=0, word_done=0, sum_word=0.
- WIDTH=4, bits (a,b) LSB first = (1,1),(1,0),(1,1),(1,1) with cin=1 on bit 0 -> s/cout per cycle:
  - 1/1, 0/1, 1/1, 1/1.
  - word_done on the 4th output cycle; sum_word=4'b1101; final cout=1 (15+13+1=29).
- cin ignored mid-word: same word as above but toggle cin=1 on bits 1-3 -> identical outputs.
- Back-to-back words: word (0,0)x4 with cin=0, then immediately word (1,0),(0,0),(0,0),(0,0) with cin=0:
  - Second word gives sum_word=4'b0001, cout=0.
  - Shows no carry leakage across the word boundary.
- Mid-word reset: after 2 bits of a word, pulse reset=0 for one cycle -> outputs clear at once.
  - The next word starts at bit 0 with cin; sum_word is unchanged from 0.
- With SERIAL_ADDER_OVF_EN: A=4'b0111, B=4'b0001, cin=0 -> sum_word=4'b1000, cout=0, ovf=1.
